// File: rtl/cpu_pkg.sv
// Shared core definitions: default widths, reset/start address and the
// program-counter sequencing states.
package cpu_pkg;

  localparam int unsigned PC_W      = 10;
  localparam int unsigned LUT_IDX_W = 4;

  localparam logic [PC_W-1:0] START_PC = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pc_state_t;

endpackage

// File: rtl/branch_lut.sv
// Programmable branch-target table: one synchronous write port, one
// combinational read port, cleared by asynchronous reset.
module branch_lut #(
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned DATA_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int unsigned DEPTH = 2 ** IDX_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read sees the pre-edge contents, so a colliding write is not forwarded.
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter / control-flow stage: start-run-done sequencing, next-PC
// selection from ALU branch flags, and the shift-carry feedback register.
module pc_ctrl #(
  parameter int unsigned PC_W      = cpu_pkg::PC_W,
  parameter int unsigned LUT_IDX_W = cpu_pkg::LUT_IDX_W,
  parameter logic [PC_W-1:0] START_PC = PC_W'(cpu_pkg::START_PC)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 halt,
  input  logic                 br_ne,
  input  logic                 br_lt,
  input  logic                 notequal,
  input  logic                 lessthan,
  input  logic [LUT_IDX_W-1:0] lut_idx,
  input  logic                 sc_o,
  input  logic                 sc_we,
  input  logic                 sc_clr,
  input  logic                 lut_we,
  input  logic [LUT_IDX_W-1:0] lut_waddr,
  input  logic [PC_W-1:0]      lut_wdata,
  output logic [PC_W-1:0]      prog_ctr,
  output logic                 sc_in,
  output logic                 branch_taken,
  output logic                 running,
  output logic                 done
);

  import cpu_pkg::*;

  pc_state_t       r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_sc;
  logic [PC_W-1:0] w_lut_target;
  logic            w_branch;

  branch_lut #(
    .IDX_W  (LUT_IDX_W),
    .DATA_W (PC_W)
  ) u_branch_lut (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_we    (lut_we),
    .i_waddr (lut_waddr),
    .i_wdata (lut_wdata),
    .i_raddr (lut_idx),
    .o_rdata (w_lut_target)
  );

  // An illegal br_ne+br_lt decode simply ORs the two conditions.
  assign w_branch = (r_state == RUN) &&
                    ((br_ne && notequal) || (br_lt && lessthan));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_pc    <= START_PC;
      r_sc    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_pc <= START_PC;
          if (start) begin
            r_state <= RUN;
            r_sc    <= 1'b0;
          end
        end
        RUN: begin
          if (halt) begin
            r_state <= DONE;
          end else if (w_branch) begin
            r_pc <= w_lut_target;
          end else begin
            r_pc <= r_pc + PC_W'(1);
          end
          // Shift-carry still updates on the halting instruction.
          if (sc_clr) begin
            r_sc <= 1'b0;
          end else if (sc_we) begin
            r_sc <= sc_o;
          end
        end
        DONE: begin
          if (start) begin
            r_state <= RUN;
            r_pc    <= START_PC;
            r_sc    <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_pc    <= START_PC;
          r_sc    <= 1'b0;
        end
      endcase
    end
  end

  assign prog_ctr     = r_pc;
  assign sc_in        = r_sc;
  assign branch_taken = w_branch;
  assign running      = (r_state == RUN);
  assign done         = (r_state == DONE);

endmodule

// File: tb/tb_pc_ctrl.sv
// Scoreboard bench for pc_ctrl: directed per-cycle vectors push expected
// outputs; a negedge monitor pops and compares them.
module tb_pc_ctrl;

  localparam int unsigned PC_W  = 10;
  localparam int unsigned IDX_W = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start, halt, br_ne, br_lt, notequal, lessthan;
  logic [IDX_W-1:0] lut_idx;
  logic             sc_o, sc_we, sc_clr, lut_we;
  logic [IDX_W-1:0] lut_waddr;
  logic [PC_W-1:0]  lut_wdata;
  logic [PC_W-1:0]  prog_ctr;
  logic             sc_in, branch_taken, running, done;

  pc_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .halt         (halt),
    .br_ne        (br_ne),
    .br_lt        (br_lt),
    .notequal     (notequal),
    .lessthan     (lessthan),
    .lut_idx      (lut_idx),
    .sc_o         (sc_o),
    .sc_we        (sc_we),
    .sc_clr       (sc_clr),
    .lut_we       (lut_we),
    .lut_waddr    (lut_waddr),
    .lut_wdata    (lut_wdata),
    .prog_ctr     (prog_ctr),
    .sc_in        (sc_in),
    .branch_taken (branch_taken),
    .running      (running),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic [PC_W-1:0] pc;
    logic            sc;
    logic            bt;
    logic            run;
    logic            dn;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic compare(input exp_t e);
    n_vec++;
    if (prog_ctr !== e.pc || sc_in !== e.sc || branch_taken !== e.bt ||
        running !== e.run || done !== e.dn) begin
      n_fail++;
      $display("FAIL %s: got pc=%h sc=%b bt=%b run=%b done=%b, want pc=%h sc=%b bt=%b run=%b done=%b",
               e.name, prog_ctr, sc_in, branch_taken, running, done,
               e.pc, e.sc, e.bt, e.run, e.dn);
    end
  endtask

  // Monitor: outputs for a cycle are sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      compare(q.pop_front());
    end
  end

  task automatic clr_in();
    start = 0; halt = 0; br_ne = 0; br_lt = 0; notequal = 0; lessthan = 0;
    lut_idx = '0; sc_o = 0; sc_we = 0; sc_clr = 0; lut_we = 0;
    lut_waddr = '0; lut_wdata = '0;
  endtask

  // Expect outputs for the current cycle's inputs, then advance one cycle.
  task automatic vec(input string name, input logic [PC_W-1:0] pc,
                     input logic sc, input logic bt, input logic run,
                     input logic dn);
    exp_t e;
    e.name = name; e.pc = pc; e.sc = sc; e.bt = bt; e.run = run; e.dn = dn;
    q.push_back(e);
    @(posedge clk);
    #1;
    clr_in();
  endtask

  task automatic lut_load(input logic [IDX_W-1:0] a, input logic [PC_W-1:0] d);
    lut_we = 1; lut_waddr = a; lut_wdata = d;
    vec("idle_lut_load", 10'h000, 0, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    exp_t e;
    clr_in();
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1;
    vec("reset_state", 10'h000, 0, 0, 0, 0);
    reset_n = 1;

    lut_load(4'd3, 10'h120);
    lut_load(4'd4, 10'h007);
    lut_load(4'd2, 10'h011);
    lut_load(4'd5, 10'h3FE);

    start = 1;                   vec("idle_start",  10'h000, 0, 0, 0, 0);
    start = 1;                   vec("run_ign_st",  10'h000, 0, 0, 1, 0);
    vec("seq_pc1", 10'h001, 0, 0, 1, 0);
    vec("seq_pc2", 10'h002, 0, 0, 1, 0);
    vec("seq_pc3", 10'h003, 0, 0, 1, 0);
    vec("seq_pc4", 10'h004, 0, 0, 1, 0);
    br_ne = 1; notequal = 1; lut_idx = 4'd3;
    vec("bneq_taken", 10'h005, 0, 1, 1, 0);
    br_lt = 1; lessthan = 1; lut_idx = 4'd4;
    vec("blt_taken", 10'h120, 0, 1, 1, 0);
    br_lt = 1; lessthan = 0; notequal = 1; lut_idx = 4'd3;
    vec("blt_untaken", 10'h007, 0, 0, 1, 0);
    sc_we = 1; sc_o = 1;
    vec("sc_write", 10'h008, 0, 0, 1, 0);
    sc_we = 1; sc_clr = 1; sc_o = 1;
    vec("sc_visible", 10'h009, 1, 0, 1, 0);
    sc_we = 1; sc_o = 1;
    vec("sc_clr_prio", 10'h00A, 0, 0, 1, 0);
    br_ne = 1; notequal = 1; lut_idx = 4'd5;
    vec("br_to_top", 10'h00B, 1, 1, 1, 0);
    vec("pc_3fe", 10'h3FE, 1, 0, 1, 0);
    vec("pc_3ff", 10'h3FF, 1, 0, 1, 0);
    br_ne = 1; notequal = 1; lut_idx = 4'd2;
    lut_we = 1; lut_waddr = 4'd2; lut_wdata = 10'h055;
    vec("wrap_collide", 10'h000, 1, 1, 1, 0);
    br_ne = 1; notequal = 1; lut_idx = 4'd2;
    vec("old_lut_val", 10'h011, 1, 1, 1, 0);
    halt = 1; br_ne = 1; notequal = 1; lut_idx = 4'd3;
    vec("new_lut_halt", 10'h055, 1, 1, 1, 0);
    br_ne = 1; notequal = 1;
    vec("done_hold", 10'h055, 1, 0, 0, 1);
    start = 1;
    vec("done_start", 10'h055, 1, 0, 0, 1);
    lut_we = 1; lut_waddr = 4'd6; lut_wdata = 10'h040;
    vec("restart_sc0", 10'h000, 0, 0, 1, 0);
    br_lt = 1; lessthan = 1; lut_idx = 4'd6;
    vec("br_to_040", 10'h001, 0, 1, 1, 0);
    br_ne = 1; notequal = 1; lut_idx = 4'd3; sc_we = 1; sc_o = 1;
    e.name = "at_040"; e.pc = 10'h040; e.sc = 0; e.bt = 1; e.run = 1; e.dn = 0;
    q.push_back(e);

    // Asynchronous reset between edges, checked immediately.
    @(negedge clk);
    #2;
    reset_n = 0;
    #1;
    e.name = "async_reset"; e.pc = 10'h000; e.sc = 0; e.bt = 0; e.run = 0; e.dn = 0;
    compare(e);
    @(posedge clk);
    #1;
    clr_in();
    reset_n = 1;
    start = 1;
    vec("post_rst_idle", 10'h000, 0, 0, 0, 0);
    br_ne = 1; notequal = 1; lut_idx = 4'd3;
    vec("post_rst_br", 10'h000, 0, 1, 1, 0);
    vec("lut_cleared", 10'h000, 0, 0, 1, 0);
    vec("post_rst_pc1", 10'h001, 0, 0, 1, 0);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
Program-counter and control-flow stage directly downstream of the ALU. Consumes the ALU branch flags (notequal, lessthan) and the shift-carry output (sc_o). Produces the next instruction address and the registered shift-carry bit fed back to the ALU sc_in. Also owns the programmable branch-target lookup table and the start/run/done sequencing for the core.

Parameters:
PC_W, 10, program counter width in bits; instruction memory depth is 2**PC_W.
LUT_IDX_W, 4, branch-target LUT index width; the LUT has 2**LUT_IDX_W entries of PC_W bits.
START_PC, 0, address loaded on start.

Ports:
clk  input  1  core clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
start  input  1  level; begins or restarts execution.
halt  input  1  decoder: current instruction is halt.
br_ne  input  1  decoder: current instruction is bneq.
br_lt  input  1  decoder: current instruction is blt.
notequal  input  1  ALU flag.
lessthan  input  1  ALU flag.
lut_idx  input  LUT_IDX_W  branch target index from instruction immediate.
sc_o  input  1  ALU shift-carry out.
sc_we  input  1  decoder: capture sc_o this cycle.
sc_clr  input  1  decoder: clear shift-carry.
lut_we  input  1  LUT write enable (program load).
lut_waddr  input  LUT_IDX_W  LUT write index.
lut_wdata  input  PC_W  LUT write data.
prog_ctr  output  PC_W  current instruction address (registered).
sc_in  output  1  registered shift-carry to ALU.
branch_taken  output  1  combinational; branch resolves taken this cycle.
running  output  1  state == RUN.
done  output  1  state == DONE.

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE; prog_ctr = START_PC; sc_in = 0; all LUT entries = 0. branch_taken = 0, running = 0, done = 0.
- States: IDLE, RUN, DONE.
- IDLE: prog_ctr holds START_PC. If start = 1, next state is RUN and prog_ctr = START_PC.
- RUN: one instruction per cycle. Next-PC priority:
  - halt: state becomes DONE; prog_ctr holds.
  - branch_taken: prog_ctr = lut[lut_idx].
  - otherwise: prog_ctr = prog_ctr + 1, modulo 2**PC_W (all-ones wraps to 0).
- RUN ignores start.
- branch_taken = running & ((br_ne & notequal) | (br_lt & lessthan)). br_ne and br_lt both high is an illegal decode and is treated as OR. branch_taken is 0 outside RUN.
- DONE: prog_ctr holds; done = 1. If start = 1, next state is RUN, prog_ctr = START_PC, and sc_in is cleared.
- Shift-carry register:
  - Updates only in RUN. sc_clr has priority: it loads 0. Otherwise sc_we loads sc_o.
  - Writes from the same cycle are visible on sc_in the following cycle.
  - A start transition clears it.
- LUT:
  - Written on the clock edge when lut_we = 1, in any state.
  - Read is combinational. A same-cycle write and read of the same index returns the old value (write-after-read).
- reset_n asserted mid-RUN aborts immediately, and all outputs take their reset values asynchronously.
- Latency: flags sampled in cycle N determine prog_ctr in cycle N+1. There are no stalls and no delay slots.

Decomposition:
- Shared package cpu_pkg:
  - PC_W and LUT_IDX_W defaults.
  - pc_state_t enum {IDLE, RUN, DONE}.
  - START_PC constant.
- Sub-module branch_lut: register array with one synchronous write port, one combinational read port and asynchronous reset clear.
- pc_ctrl instantiates branch_lut and holds the FSM, the PC register and the sc register.

Test Plan:
1. Sequential fetch: reset, then start pulse, no branches. prog_ctr reads 0,1,2,3 on successive cycles; running = 1.
2. Taken bneq: load lut[3] = 0x120. In RUN at pc = 5, assert br_ne = 1, notequal = 1, lut_idx = 3. branch_taken = 1 that cycle; next prog_ctr = 0x120.
3. Untaken blt and priority:
   - At pc = 7, br_lt = 1, lessthan = 0: next prog_ctr = 8.
   - halt = 1 together with a taken bneq: state goes to DONE, prog_ctr holds 8, done = 1.
4. Wrap and collision:
   - pc = 0x3FF, no branch: next prog_ctr = 0x000.
   - lut_we to index 2 with 0x055 while branching on index 2 (old value 0x011): next prog_ctr = 0x011. A later branch on index 2 gives 0x055.
5. Shift-carry:
   - sc_we = 1, sc_o = 1: sc_in = 1 the next cycle.
   - sc_we = 1 with sc_clr = 1: sc_in = 0.
   - Assert start from DONE with sc_in = 1: sc_in = 0 and prog_ctr = 0.
6. Reset mid-run: at pc = 0x040 in RUN, pulse reset_n low between clock edges. prog_ctr = 0 and running = 0 immediately, and the LUT reads 0 afterwards.
